// File: rtl/cussen_repeat_engine.sv
// Dedups an N-element vector, multiplies each distinct value by a scalar on one shared
// multiplier, then re-expands the products to N lanes. One vector in flight at a time.
module cussen_repeat_engine #(
    parameter int N        = 9,
    parameter int W        = 8,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1,
    parameter int CW       = $clog2(N+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic [W-1:0]       scalar,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*OUT_W-1:0] out_data,
    output logic [CW-1:0]      unique_count,
    output logic [N*CW-1:0]    pointers,
    output logic [CW-1:0]      mults_saved,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, SCAN, MUL, EXPAND, HOLD} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       vec_q  [N];
    logic [W-1:0]       vec_d  [N];
    logic [W-1:0]       uniq_q [N];
    logic [W-1:0]       uniq_d [N];
    logic [CW-1:0]      ptr_q  [N];
    logic [CW-1:0]      ptr_d  [N];
    logic [OUT_W-1:0]   res_q  [N];
    logic [OUT_W-1:0]   res_d  [N];
    logic [W-1:0]       scalar_q, scalar_d;
    logic [CW-1:0]      u_q, u_d, idx_q, idx_d, k_q, k_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [N*OUT_W-1:0] out_data_q, out_data_d;
    logic [N*CW-1:0]    pointers_q, pointers_d;
    logic [CW-1:0]      unique_count_q, unique_count_d, mults_saved_q, mults_saved_d;

    logic [W-1:0]       elem, mul_op;
    logic               hit;
    logic [CW-1:0]      hit_j;
    logic [2*W-1:0]     prod;
    logic [OUT_W-1:0]   res_val;

    // Datapath helpers: current scan element, its table hit, and the shared product.
    always_comb begin
        elem   = '0;
        mul_op = '0;
        hit    = 1'b0;
        hit_j  = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == CW'(i)) elem = vec_q[i];
            if (k_q == CW'(i))   mul_op = uniq_q[i];
        end
        for (int j = 0; j < N; j++) begin
            if (!hit && (CW'(j) < u_q) && (uniq_q[j] == elem)) begin
                hit   = 1'b1;
                hit_j = CW'(j);
            end
        end
        prod = {{W{1'b0}}, mul_op} * {{W{1'b0}}, scalar_q};
        if ((SATURATE != 0) && ((prod >> OUT_W) != '0)) res_val = '1;
        else                                            res_val = prod[OUT_W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        uniq_d         = uniq_q;
        ptr_d          = ptr_q;
        res_d          = res_q;
        scalar_d       = scalar_q;
        u_d            = u_q;
        idx_d          = idx_q;
        k_d            = k_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        pointers_d     = pointers_q;
        unique_count_d = unique_count_q;
        mults_saved_d  = mults_saved_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < N; i++) begin
                        vec_d[i]  = in_data[i*W +: W];
                        uniq_d[i] = '0;
                    end
                    scalar_d = scalar;
                    u_d      = '0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == CW'(i)) ptr_d[i] = hit ? hit_j : u_q;
                    if (!hit && (u_q == CW'(i))) uniq_d[i] = elem;
                end
                if (!hit) u_d = u_q + CW'(1);
                if (idx_q == CW'(N-1)) begin
                    k_d     = '0;
                    state_d = MUL;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            MUL: begin
                for (int i = 0; i < N; i++) begin
                    if (k_q == CW'(i)) res_d[i] = res_val;
                end
                if (k_q == u_q - CW'(1)) state_d = EXPAND;
                else                     k_d = k_q + CW'(1);
            end
            EXPAND: begin
                for (int i = 0; i < N; i++) begin
                    out_data_d[i*OUT_W +: OUT_W] = '0;
                    for (int j = 0; j < N; j++) begin
                        if (ptr_q[i] == CW'(j)) out_data_d[i*OUT_W +: OUT_W] = res_q[j];
                    end
                    pointers_d[i*CW +: CW] = ptr_q[i];
                end
                unique_count_d = u_q;
                mults_saved_d  = CW'(N) - u_q;
                out_valid_d    = 1'b1;
                state_d        = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            for (int i = 0; i < N; i++) begin
                vec_q[i]  <= '0;
                uniq_q[i] <= '0;
                ptr_q[i]  <= '0;
                res_q[i]  <= '0;
            end
            scalar_q       <= '0;
            u_q            <= '0;
            idx_q          <= '0;
            k_q            <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            out_data_q     <= '0;
            pointers_q     <= '0;
            unique_count_q <= '0;
            mults_saved_q  <= '0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            uniq_q         <= uniq_d;
            ptr_q          <= ptr_d;
            res_q          <= res_d;
            scalar_q       <= scalar_d;
            u_q            <= u_d;
            idx_q          <= idx_d;
            k_q            <= k_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            out_data_q     <= out_data_d;
            pointers_q     <= pointers_d;
            unique_count_q <= unique_count_d;
            mults_saved_q  <= mults_saved_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign out_data     = out_data_q;
    assign pointers     = pointers_q;
    assign unique_count = unique_count_q;
    assign mults_saved  = mults_saved_q;

endmodule
